// File: rtl/multi_project_mux.sv
// rtl/multi_project_mux.sv - Wishbone-controlled project selector and pad arbiter
module multi_project_mux #(
  parameter int          NUM_PROJ     = 4,
  parameter int          NIO          = 38,
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
  parameter int          GUARD_CYCLES = 4,
  parameter int          RST_HOLD     = 16,
  parameter int          DEFAULT_SEL  = 0,
  parameter int          DEFAULT_EN   = 1
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_n,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_we_i,
  input  logic [3:0]              wbs_sel_i,
  input  logic [31:0]             wbs_adr_i,
  input  logic [31:0]             wbs_dat_i,
  output logic                    wbs_ack_o,
  output logic [31:0]             wbs_dat_o,
  input  logic [NUM_PROJ*NIO-1:0] proj_io_out,
  input  logic [NUM_PROJ*NIO-1:0] proj_io_oeb,
  input  logic [NUM_PROJ*3-1:0]   proj_irq,
  output logic [NUM_PROJ-1:0]     proj_rst_n,
  output logic [NIO-1:0]          io_out,
  output logic [NIO-1:0]          io_oeb,
  output logic [2:0]              user_irq
);

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_ISOLATE = 3'd1,
    S_SWITCH  = 3'd2,
    S_HOLD    = 3'd3,
    S_RUN     = 3'd4
  } state_t;

  state_t      state;
  logic [3:0]  ctrl_sel;
  logic        ctrl_en;
  logic [15:0] hold_reg;
  logic [15:0] hold_lat;
  logic [2:0]  irq_mask;
  logic        err;
  logic [3:0]  active_sel;
  logic [15:0] cnt;

  logic        hit, acc, wr, busy, ctrl_wr, start, sel_bad, run;
  logic [1:0]  off;
  logic [31:0] rdata;
  logic [NIO-1:0] act_out, act_oeb;
  logic [2:0]  act_irq;
  logic        unused_bits;

  // Ack only on the first cycle of a held strobe so every access gets a gap.
  assign hit     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign acc     = hit & ~wbs_ack_o;
  assign wr      = acc & wbs_we_i;
  assign off     = wbs_adr_i[3:2];
  assign busy    = (state == S_ISOLATE) || (state == S_SWITCH) || (state == S_HOLD);
  assign ctrl_wr = wr && (off == 2'd0);
  assign start   = ctrl_wr && !busy;
  assign sel_bad = ({28'd0, ctrl_sel} >= 32'(NUM_PROJ));
  assign run     = (state == S_RUN);

  assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i[31:18], wbs_dat_i[16], wbs_sel_i[3]};

  always_comb begin
    act_out = '0;
    act_oeb = '1;
    act_irq = '0;
    for (int k = 0; k < NUM_PROJ; k++) begin
      if (active_sel == 4'(k)) begin
        act_out = proj_io_out[k*NIO +: NIO];
        act_oeb = proj_io_oeb[k*NIO +: NIO];
        act_irq = proj_irq[k*3 +: 3];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_PROJ; k++) begin
      proj_rst_n[k] = run && (active_sel == 4'(k));
    end
    io_out = run ? act_out : '0;
    io_oeb = run ? act_oeb : '1;
  end

  always_comb begin
    rdata = '0;
    case (off)
      2'd0: rdata = {23'd0, ctrl_en, 4'd0, ctrl_sel};
      2'd1: rdata = {14'd0, err, busy, 4'd0, active_sel, 5'd0, state};
      2'd2: rdata = {16'd0, hold_reg};
      default: rdata = {29'd0, irq_mask};
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      wbs_ack_o  <= 1'b0;
      wbs_dat_o  <= '0;
      ctrl_sel   <= 4'(DEFAULT_SEL);
      ctrl_en    <= 1'(DEFAULT_EN);
      hold_reg   <= 16'(RST_HOLD);
      hold_lat   <= 16'(RST_HOLD);
      irq_mask   <= 3'b111;
      err        <= 1'b0;
      active_sel <= 4'(DEFAULT_SEL);
      cnt        <= '0;
      state      <= S_ISOLATE;
      user_irq   <= '0;
    end else begin
      wbs_ack_o <= acc;
      wbs_dat_o <= acc ? rdata : '0;

      if (start) begin
        if (wbs_sel_i[0]) ctrl_sel <= wbs_dat_i[3:0];
        if (wbs_sel_i[1]) ctrl_en  <= wbs_dat_i[8];
      end

      if (ctrl_wr && busy) begin
        err <= 1'b1;
      end else if (wr && off == 2'd1 && wbs_sel_i[2] && wbs_dat_i[17]) begin
        err <= 1'b0;
      end

      if (wr && off == 2'd2) begin
        if (wbs_sel_i[0]) hold_reg[7:0]  <= wbs_dat_i[7:0];
        if (wbs_sel_i[1]) hold_reg[15:8] <= wbs_dat_i[15:8];
      end

      if (wr && off == 2'd3 && wbs_sel_i[0]) irq_mask <= wbs_dat_i[2:0];

      // Irq drops in the same edge that leaves RUN, not one cycle later.
      user_irq <= (run && !start) ? (act_irq & irq_mask) : 3'b000;

      case (state)
        S_ISOLATE: begin
          if (cnt == 16'(GUARD_CYCLES - 1)) begin
            state <= S_SWITCH;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_SWITCH: begin
          active_sel <= ctrl_sel;
          hold_lat   <= hold_reg;
          cnt        <= '0;
          state      <= (!ctrl_en || sel_bad) ? S_OFF : S_HOLD;
        end
        S_HOLD: begin
          // HOLD=0 still spends one cycle here, same as HOLD=1.
          if (({1'b0, cnt} + 17'd1) >= {1'b0, hold_lat}) begin
            state <= S_RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          if (start) begin
            state <= S_ISOLATE;
            cnt   <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/multi_project_mux.md
Name: multi_project_mux

Overview:
- Parametrised top-level project selector and pad arbiter. Hosts NUM_PROJ wrapped user designs behind one set of Caravel pads.
- Wishbone-programmable: firmware picks the active project, and the block runs a safe switch-over sequence (isolate pads, hold resets, switch the mux, release reset).
- Sits directly under user_project_wrapper. Every wrapped design's io_out, io_oeb and irq route through it.
- io_in fans out to all projects outside this block.

Parameters:
- NUM_PROJ, 4, number of hosted projects (2..16).
- NIO, 38, pad count muxed.
- BASE_ADDR, 32'h3000_0000, Wishbone base; decode uses adr[31:4].
- GUARD_CYCLES, 4, isolation cycles before the mux switches (>=1).
- RST_HOLD, 16, reset value of the HOLD register.
- DEFAULT_SEL, 0, project selected out of reset.
- DEFAULT_EN, 1, enable state out of reset.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_n  in  1  asynchronous active-low reset.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte selects.
- wbs_adr_i  in  32  address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- proj_io_out  in  NUM_PROJ*NIO  per-project pad outputs; project k at [k*NIO +: NIO].
- proj_io_oeb  in  NUM_PROJ*NIO  per-project pad output-enable-bar.
- proj_irq  in  NUM_PROJ*3  per-project irq.
- proj_rst_n  out  NUM_PROJ  per-project active-low reset.
- io_out  out  NIO  to pads.
- io_oeb  out  NIO  to pads.
- user_irq  out  3  to management core.

Behaviour:
- Register map (offset = adr[3:0]):
  - 0x0 CTRL RW: [3:0] sel, [8] en.
  - 0x4 STATUS RO/W1C: [2:0] state, [11:8] active_sel, [16] busy, [17] err (sticky, write 1 to clear).
  - 0x8 HOLD RW: [15:0] reset hold cycles.
  - 0xC IRQMASK RW: [2:0].
- Byte writes honour wbs_sel_i.
- Wishbone handshake:
  - Access in window (adr[31:4]==BASE_ADDR[31:4], cyc&stb) gets ack registered one cycle later, pulsed for one cycle.
  - No back-to-back ack on a held strobe: ack deasserts for at least one cycle between accesses.
  - Read data is valid with ack. Offsets with adr[1:0]!=0 alias to the word.
  - Out-of-window accesses are never acked; wbs_dat_o holds 0.
- FSM states: OFF(0), ISOLATE(1), SWITCH(2), HOLD(3), RUN(4).
  - ISOLATE: io_oeb all 1, io_out all 0, all proj_rst_n 0, guard counter counts GUARD_CYCLES cycles, then SWITCH.
  - SWITCH: one cycle; active_sel <= CTRL.sel. Next state is OFF if en=0 or sel>=NUM_PROJ, otherwise HOLD.
  - HOLD: pads still isolated, counts HOLD cycles. HOLD=0 goes to RUN on the next cycle.
  - RUN: proj_rst_n[active_sel]=1, all others 0. io_out/io_oeb are combinational copies of the active project's slices.
  - OFF: same outputs as ISOLATE, indefinitely.
- Triggers:
  - Any CTRL write accepted in OFF or RUN enters ISOLATE the next cycle, even with an unchanged value; this is the soft reset of the running project.
  - A CTRL write while busy (ISOLATE/SWITCH/HOLD) is acked but discarded, and sets err.
  - HOLD/IRQMASK writes are always accepted; a HOLD write during HOLD affects the next sequence only.
- Reset:
  - wb_rst_n low forces: state ISOLATE, CTRL={DEFAULT_EN,DEFAULT_SEL}, HOLD=RST_HOLD, IRQMASK=3'b111, err=0, counters 0.
  - Outputs in reset: wbs_ack_o 0, wbs_dat_o 0, io_oeb all 1, io_out all 0, proj_rst_n all 0, user_irq 0.
  - On release the sequence runs unprompted: RUN is reached after GUARD_CYCLES+1+HOLD cycles.
  - Reset asserted mid-sequence or in RUN restarts from ISOLATE asynchronously.
- busy = state in {ISOLATE, SWITCH, HOLD}.
- user_irq: registered, = proj_irq[active_sel] & IRQMASK in RUN, otherwise 0. Goes to 0 on the first cycle after leaving RUN.

Test Plan:
- Reset release, defaults (NUM_PROJ=4, GUARD=4, HOLD=16): io_oeb all 1 for 21 cycles after release, then proj_rst_n=4'b0001, STATUS reads 0x0000_0004, io_out tracks project 0.
- Write CTRL=0x103 in RUN: io_oeb all 1 for 4+1+16 cycles, proj_rst_n=0000 throughout, then 4'b1000, STATUS[11:8]=3.
- Write CTRL=0x105 (sel>=NUM_PROJ), then CTRL=0x002 (en=0): both end in OFF (state 0), pads isolated, proj_rst_n=0000, user_irq=0.
- Write HOLD=0 then CTRL=0x101: RUN reached exactly 6 cycles after ack. A second CTRL write during ISOLATE is acked, ignored, and STATUS[17]=1; write 0x20000 to STATUS clears it.
- Irq gating: project 1 active, proj_irq slice=3'b101, IRQMASK=3'b100 -> user_irq=3'b100 one cycle later. Soft reset write -> user_irq=0 the next cycle.
- Bus edges: read at adr 0x3000_0010 gets no ack for 8 cycles; byte write sel=4'b0010 to CTRL changes only en. Reading CTRL at offset 0x2 returns the same word as offset 0x0. Assert wb_rst_n mid-HOLD -> outputs return to reset values within the same cycle.
